score_glyph_reader: RTL and testbench

- Reader side of the score bitmap: recovers the three decimal digits drawn into the 769-bit score bitmap (16-pixel row stride, 3x5 glyphs) and returns them as BCD plus a binary value.
- Reads the bitmap one pixel per cycle through a registered read port, so the drawing logic and this checker can share one bitmap store.
- Used for score readback, self-check and debug overlay.

---
 rtl/score_glyph_reader.sv | 153 +++++++++++++++
 tb/tb_score_glyph_reader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/score_glyph_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | score_glyph_reader                                                 |
// | Reads three 3x5 glyphs from the score bitmap and decodes BCD/value |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module score_glyph_reader #(
  parameter int ADDR_W      = 10,
  parameter int BITMAP_BITS = 769,
  parameter int ROW_STRIDE  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3*ADDR_W-1:0]   req_base,
  output logic                  pix_rd,
  output logic [ADDR_W-1:0]     pix_addr,
  input  logic                  pix_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [11:0]           out_digits,
  output logic [9:0]            out_value,
  output logic                  out_err
);

  localparam logic [ADDR_W-1:0] c_max_base = ADDR_W'(BITMAP_BITS - 1 - (4*ROW_STRIDE + 2));
  localparam logic [ADDR_W-1:0] c_row_step = ADDR_W'(ROW_STRIDE - 2);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, CHECK = 2'd2, DONE = 2'd3} state_t;

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_base2, r_base3, r_addr;
  logic [1:0]          r_idx, r_col;
  logic [3:0]          r_cnt;
  logic                r_oor, r_rd_d;
  logic [14:0]         r_shift;
  logic [3:0]          r_dig1, r_dig2;
  logic [ADDR_W-1:0]   w_start_base;
  logic                w_start_oor;
  logic [3:0]          w_glyph;
  logic                w_err;
  logic [9:0]          w_value;

  // Glyph rows are matched in drawing order: bit 14 is row0/col0.
  function automatic logic [3:0] decode(input logic [14:0] px);
    logic [14:0] s;
    for (int i = 0; i < 15; i++) s[14-i] = px[i];
    case (s)
      15'b111_101_101_101_111: decode = 4'd0;
      15'b001_001_001_001_001: decode = 4'd1;
      15'b111_001_111_100_111: decode = 4'd2;
      15'b111_001_111_001_111: decode = 4'd3;
      15'b101_101_111_001_001: decode = 4'd4;
      15'b111_100_111_001_111: decode = 4'd5;
      15'b111_100_111_101_111: decode = 4'd6;
      15'b111_001_001_001_001: decode = 4'd7;
      15'b111_101_111_101_111: decode = 4'd8;
      15'b111_101_111_001_111: decode = 4'd9;
      15'b000_000_000_000_000: decode = 4'hE;
      default:                 decode = 4'hF;
    endcase
  endfunction

  function automatic logic [9:0] bin(input logic [3:0] d);
    bin = (d <= 4'd9) ? {6'd0, d} : 10'd0;
  endfunction

  assign req_ready = (r_state == IDLE);
  assign pix_rd    = (r_state == READ);
  assign pix_addr  = pix_rd ? r_addr : '0;
  assign out_valid = (r_state == DONE);

  always_comb begin
    w_start_base = r_base3;
    if (r_state == IDLE)   w_start_base = req_base[3*ADDR_W-1 -: ADDR_W];
    else if (r_idx == 2'd0) w_start_base = r_base2;
    w_start_oor = (w_start_base > c_max_base);
    // The final pixel arrives during CHECK, so it is merged in directly.
    w_glyph = r_oor ? 4'hF : decode({pix_data, r_shift[14:1]});
    w_err   = (r_dig1 == 4'hF) || (r_dig2 == 4'hF) || (w_glyph == 4'hF);
    w_value = w_err ? 10'd0 : (bin(r_dig1) * 10'd100 + bin(r_dig2) * 10'd10 + bin(w_glyph));
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (req_valid) w_next = w_start_oor ? CHECK : READ;
      READ:  if (r_cnt == 4'd14) w_next = CHECK;
      CHECK: if (r_idx == 2'd2) w_next = DONE;
             else           w_next = w_start_oor ? CHECK : READ;
      DONE:  if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_base2 <= '0; r_base3 <= '0; r_addr <= '0;
      r_idx <= '0; r_col <= '0; r_cnt <= '0;
      r_oor <= 1'b0; r_rd_d <= 1'b0; r_shift <= '0;
      r_dig1 <= '0; r_dig2 <= '0;
      out_digits <= '0; out_value <= '0; out_err <= 1'b0;
    end else begin
      r_rd_d <= pix_rd;
      if (r_rd_d) r_shift <= {pix_data, r_shift[14:1]};
      case (r_state)
        IDLE: if (req_valid) begin
          r_base2 <= req_base[2*ADDR_W-1 -: ADDR_W];
          r_base3 <= req_base[ADDR_W-1:0];
          r_idx   <= 2'd0;
          r_addr  <= w_start_base;
          r_col   <= 2'd0;
          r_cnt   <= 4'd0;
          r_oor   <= w_start_oor;
        end
        READ: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_col == 2'd2) begin
            r_col  <= 2'd0;
            r_addr <= r_addr + c_row_step;
          end else begin
            r_col  <= r_col + 2'd1;
            r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
        CHECK: begin
          if (r_idx == 2'd0) r_dig1 <= w_glyph;
          if (r_idx == 2'd1) r_dig2 <= w_glyph;
          if (r_idx == 2'd2) begin
            out_digits <= {r_dig1, r_dig2, w_glyph};
            out_err    <= w_err;
            out_value  <= w_value;
          end else begin
            r_idx  <= r_idx + 2'd1;
            r_addr <= w_start_base;
            r_col  <= 2'd0;
            r_cnt  <= 4'd0;
            r_oor  <= w_start_oor;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_score_glyph_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_score_glyph_reader                                              |
// | Randomized bench with a bitmap-level reference model               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_score_glyph_reader;
  localparam int ADDR_W = 10;
  localparam int BITS   = 769;
  localparam int STRIDE = 16;
  localparam int MAXB   = BITS - 1 - (4*STRIDE + 2);

  localparam logic [2:0] GLYPH [10][5] = '{
    '{3'd7, 3'd5, 3'd5, 3'd5, 3'd7}, '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1},
    '{3'd7, 3'd1, 3'd7, 3'd4, 3'd7}, '{3'd7, 3'd1, 3'd7, 3'd1, 3'd7},
    '{3'd5, 3'd5, 3'd7, 3'd1, 3'd1}, '{3'd7, 3'd4, 3'd7, 3'd1, 3'd7},
    '{3'd7, 3'd4, 3'd7, 3'd5, 3'd7}, '{3'd7, 3'd1, 3'd1, 3'd1, 3'd1},
    '{3'd7, 3'd5, 3'd7, 3'd5, 3'd7}, '{3'd7, 3'd5, 3'd7, 3'd1, 3'd7}};

  logic clk = 1'b0, resetn = 1'b0, req_valid = 1'b0, out_ready = 1'b0, pix_data = 1'b0;
  logic [3*ADDR_W-1:0] req_base = '0;
  logic req_ready, pix_rd, out_valid, out_err;
  logic [ADDR_W-1:0] pix_addr;
  logic [11:0] out_digits;
  logic [9:0] out_value;

  int n_checks = 0, n_pass = 0;
  logic mem [0:BITS-1];
  logic bad_addr = 1'b0;

  score_glyph_reader #(.ADDR_W(ADDR_W), .BITMAP_BITS(BITS), .ROW_STRIDE(STRIDE)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_base(req_base), .pix_rd(pix_rd), .pix_addr(pix_addr), .pix_data(pix_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_digits(out_digits),
    .out_value(out_value), .out_err(out_err));

  always #5 clk = ~clk;

  // Registered read port of the shared bitmap; noise when idle.
  always @(posedge clk) begin
    if (pix_rd) begin
      if (int'(pix_addr) >= BITS) begin
        bad_addr <= 1'b1;
        pix_data <= 1'b0;
      end else pix_data <= mem[pix_addr];
    end else pix_data <= 1'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < BITS; i++) mem[i] = 1'b0;
  endtask

  task automatic draw(input int base, input int d);
    logic [2:0] row;
    if (d > 9 || base > MAXB) return;
    for (int r = 0; r < 5; r++) begin
      row = GLYPH[d][r];
      for (int c = 0; c < 3; c++) mem[base + r*STRIDE + c] = row[2-c];
    end
  endtask

  function automatic logic [3:0] model_digit(input int base);
    logic [2:0] rows [5];
    logic any, match;
    if (base > MAXB) return 4'hF;
    any = 1'b0;
    for (int r = 0; r < 5; r++) begin
      rows[r] = {mem[base + r*STRIDE], mem[base + r*STRIDE + 1], mem[base + r*STRIDE + 2]};
      if (rows[r] != 3'd0) any = 1'b1;
    end
    if (!any) return 4'hE;
    for (int d = 0; d < 10; d++) begin
      match = 1'b1;
      for (int r = 0; r < 5; r++) if (rows[r] != GLYPH[d][r]) match = 1'b0;
      if (match) return 4'(d);
    end
    return 4'hF;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"},   32'(req_ready),  32'd1);
    check({tag, "_rd"},    32'(pix_rd),     32'd0);
    check({tag, "_addr"},  32'(pix_addr),   32'd0);
    check({tag, "_valid"}, 32'(out_valid),  32'd0);
    check({tag, "_dig"},   32'(out_digits), 32'd0);
    check({tag, "_val"},   32'(out_value),  32'd0);
    check({tag, "_err"},   32'(out_err),    32'd0);
  endtask

  // Called #1 after a clock edge with the DUT idle.
  task automatic run_req(input string tag, input int b1, input int b2, input int b3,
                         input int hold, input int abort_at);
    int bases [3];
    logic [3:0] ed [3];
    int ea [0:159];
    int t, cyc, seq_err, stab_err, ev;
    logic eerr;
    logic [11:0] sd;
    bases = '{b1, b2, b3};
    for (int i = 0; i < 160; i++) ea[i] = -1;
    t = 1; eerr = 1'b0; ev = 0;
    for (int i = 0; i < 3; i++) begin
      ed[i] = model_digit(bases[i]);
      if (ed[i] == 4'hF) eerr = 1'b1;
      if (ed[i] <= 4'd9) ev = ev * 10 + int'(ed[i]);
      else               ev = ev * 10;
      if (bases[i] > MAXB) t += 1;
      else begin
        for (int k = 0; k < 15; k++) ea[t+k] = bases[i] + (k/3)*STRIDE + (k%3);
        t += 16;
      end
    end
    if (eerr) ev = 0;
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_base  = {ADDR_W'(b1), ADDR_W'(b2), ADDR_W'(b3)};
    req_valid = 1'b1;
    cyc = 0; seq_err = 0;
    while (cyc < 150) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) req_valid = 1'b0;
      if (abort_at == cyc) begin
        resetn = 1'b0;
        #1;
        check_reset_vals({tag, "_abort"});
        @(posedge clk); #1;
        resetn = 1'b1;
        return;
      end
      if (out_valid) break;
      if (req_ready) seq_err++;
      if (pix_rd !== (ea[cyc] >= 0)) seq_err++;
      else if (pix_rd && int'(pix_addr) != ea[cyc]) seq_err++;
    end
    check({tag, "_rdseq"}, 32'(seq_err), 32'd0);
    check({tag, "_lat"}, 32'(cyc), 32'(t));
    check({tag, "_dig"}, 32'(out_digits), 32'({ed[0], ed[1], ed[2]}));
    check({tag, "_val"}, 32'(out_value), 32'(ev));
    check({tag, "_err"}, 32'(out_err), 32'(eerr));
    sd = out_digits; stab_err = 0;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!out_valid || req_ready || out_digits != sd) stab_err++;
    end
    if (hold > 0) check({tag, "_hold"}, 32'(stab_err), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drop"}, 32'({out_valid, req_ready}), 32'b01);
    check({tag, "_keep"}, 32'(out_digits), 32'(sd));
    check({tag, "_range"}, 32'(bad_addr), 32'd0);
  endtask

  initial begin
    int b [3];
    int d [3];
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    resetn = 1'b1;
    @(posedge clk); #1;

    clear_mem(); draw(0, 1); draw(4, 2); draw(8, 3);
    run_req("t123", 0, 4, 8, 0, 0);
    check("t123_exact", 32'(out_digits), 32'h123);

    clear_mem(); draw(100, 9); draw(104, 0); draw(108, 8);
    run_req("t908", 100, 104, 108, 10, 0);

    clear_mem(); draw(4, 4); draw(8, 7);
    run_req("tE47", 0, 4, 8, 1, 0);
    mem[1] = 1'b1;
    run_req("tcorrupt", 0, 4, 8, 0, 0);

    clear_mem(); draw(4, 5); draw(8, 6);
    run_req("toor", 703, 4, 8, 2, 0);

    clear_mem(); draw(0, 6); draw(4, 2); draw(8, 9);
    run_req("tabort", 0, 4, 8, 0, 20);
    run_req("tafter", 0, 4, 8, 0, 0);

    for (int i = 0; i < 10; i++) begin
      clear_mem();
      b = '{20*i, 400, MAXB};
      d = '{i, (i+3)%10, (i+7)%10};
      for (int j = 0; j < 3; j++) draw(b[j], d[j]);
      run_req("sweep", b[0], b[1], b[2], 0, 0);
    end
    clear_mem(); draw(0, 8); draw(200, 1);
    run_req("edge703", 0, 200, MAXB + 1, 0, 0);

    for (int i = 0; i < 20; i++) begin
      clear_mem();
      for (int j = 0; j < 3; j++) begin
        b[j] = $urandom_range(0, 720);
        draw(b[j], $urandom_range(0, 10));
      end
      if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, BITS-1)] = 1'b1;
      run_req("rand", b[0], b[1], b[2], $urandom_range(0, 3), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
